// File: rtl/oled_frame_streamer.sv
// oled_frame_streamer: streams one frame of RGB565 pixels to an SSD1331 panel over SPI mode 0.
// The frame starts with a 6-byte column/row window command. Pixels are then scanned in row-major
// order through pixel_index, and each pixel_data word is shifted out MSB first.
// Optional build macro OLED_TX_PREFETCH_EN: the next pixel is fetched into a shadow register while
// the current pixel shifts, so SCLK runs without a gap across pixel boundaries.

module oled_frame_streamer #(
    parameter int unsigned WIDTH   = 96,
    parameter int unsigned HEIGHT  = 64,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_req,
    input  logic [15:0] pixel_data,
    output logic [12:0] pixel_index,
    output logic        oled_cs_n,
    output logic        oled_sclk,
    output logic        oled_mosi,
    output logic        oled_dc,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned NPIX     = WIDTH * HEIGHT;
    localparam int unsigned DW       = $clog2(CLK_DIV) + 1;
    localparam logic [12:0] LAST_IDX = 13'(NPIX - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [7:0]  COL_END  = 8'(WIDTH - 1);
    localparam logic [7:0]  ROW_END  = 8'(HEIGHT - 1);
    localparam logic [7:0]  CMD_COL  = 8'h15;
    localparam logic [7:0]  CMD_ROW  = 8'h75;

    if (NPIX == 0 || NPIX > 8192 || CLK_DIV < 1) begin : g_param_check
        $error("oled_frame_streamer: unsupported WIDTH/HEIGHT/CLK_DIV");
    end

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StFetch,
        StShift,
        StDone
    } state_e;

    state_e          state_q;
    logic            pending_q;
    logic [DW-1:0]   div_q;
    logic [3:0]      bit_q;
    logic [2:0]      byte_q;
    logic            fetch_q;
    logic [15:0]     shift_q;
`ifdef OLED_TX_PREFETCH_EN
    logic [15:0]     shadow_q;
    logic            last_q;
`endif

    logic            half_end;
    logic            is_last;
    logic [7:0]      next_byte;

    // Window command sequence: column range then row range covering the whole panel.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    cmd_byte = CMD_COL;
            3'd1:    cmd_byte = 8'h00;
            3'd2:    cmd_byte = COL_END;
            3'd3:    cmd_byte = CMD_ROW;
            3'd4:    cmd_byte = 8'h00;
            3'd5:    cmd_byte = ROW_END;
            default: cmd_byte = 8'h00;
        endcase
    endfunction

    // Half-period timing, next command byte, and last-pixel detection.
    always_comb begin
        half_end  = (div_q == DIV_MAX);
        next_byte = cmd_byte(byte_q + 3'd1);
`ifdef OLED_TX_PREFETCH_EN
        // pixel_index leads the shifting pixel, so the last pixel is tracked separately.
        is_last   = last_q;
`else
        is_last   = (pixel_index == LAST_IDX);
`endif
    end

    // Frame sequencer: one FSM owning every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            div_q       <= '0;
            bit_q       <= 4'd0;
            byte_q      <= 3'd0;
            fetch_q     <= 1'b0;
            shift_q     <= 16'h0000;
            pixel_index <= 13'd0;
            oled_cs_n   <= 1'b1;
            oled_sclk   <= 1'b0;
            oled_mosi   <= 1'b0;
            oled_dc     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
`ifdef OLED_TX_PREFETCH_EN
            shadow_q    <= 16'h0000;
            last_q      <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            // Requests outside IDLE collapse into a single queued frame.
            if (frame_req && state_q != StIdle) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (frame_req || pending_q) begin
                        state_q   <= StCmd;
                        pending_q <= 1'b0;
                        busy      <= 1'b1;
                        oled_cs_n <= 1'b0;
                        oled_dc   <= 1'b0;
                        oled_sclk <= 1'b0;
                        div_q     <= '0;
                        bit_q     <= 4'd0;
                        byte_q    <= 3'd0;
                        oled_mosi <= CMD_COL[7];
                        shift_q   <= {CMD_COL[6:0], 9'd0};
                    end
                end

                StCmd: begin
                    if (!half_end) begin
                        div_q <= DW'(div_q + 1'b1);
                    end else begin
                        div_q <= '0;
                        if (!oled_sclk) begin
                            oled_sclk <= 1'b1;
                        end else begin
                            oled_sclk <= 1'b0;
                            if (bit_q == 4'd7) begin
                                if (byte_q == 3'd5) begin
                                    state_q     <= StFetch;
                                    pixel_index <= 13'd0;
                                    fetch_q     <= 1'b0;
                                end else begin
                                    byte_q    <= byte_q + 3'd1;
                                    bit_q     <= 4'd0;
                                    oled_mosi <= next_byte[7];
                                    shift_q   <= {next_byte[6:0], 9'd0};
                                end
                            end else begin
                                bit_q     <= bit_q + 4'd1;
                                oled_mosi <= shift_q[15];
                                shift_q   <= {shift_q[14:0], 1'b0};
                            end
                        end
                    end
                end

                StFetch: begin
                    // Index held for two cycles so a one-cycle-latency source settles.
                    if (!fetch_q) begin
                        fetch_q <= 1'b1;
                    end else begin
                        state_q   <= StShift;
                        oled_dc   <= 1'b1;
                        oled_sclk <= 1'b0;
                        div_q     <= '0;
                        bit_q     <= 4'd0;
                        oled_mosi <= pixel_data[15];
                        shift_q   <= {pixel_data[14:0], 1'b0};
`ifdef OLED_TX_PREFETCH_EN
                        if (pixel_index == LAST_IDX) begin
                            last_q <= 1'b1;
                        end else begin
                            last_q      <= 1'b0;
                            pixel_index <= pixel_index + 13'd1;
                        end
`endif
                    end
                end

                StShift: begin
`ifdef OLED_TX_PREFETCH_EN
                    // Skip bit 0 so the prefetched index has settled before capture.
                    if (bit_q != 4'd0) begin
                        shadow_q <= pixel_data;
                    end
`endif
                    if (!half_end) begin
                        div_q <= DW'(div_q + 1'b1);
                    end else begin
                        div_q <= '0;
                        if (!oled_sclk) begin
                            oled_sclk <= 1'b1;
                        end else begin
                            oled_sclk <= 1'b0;
                            if (bit_q == 4'd15) begin
                                if (is_last) begin
                                    state_q     <= StDone;
                                    oled_cs_n   <= 1'b1;
                                    oled_dc     <= 1'b0;
                                    oled_mosi   <= 1'b0;
                                    busy        <= 1'b0;
                                    frame_done  <= 1'b1;
                                    pixel_index <= 13'd0;
`ifdef OLED_TX_PREFETCH_EN
                                    last_q      <= 1'b0;
`endif
                                end else begin
`ifdef OLED_TX_PREFETCH_EN
                                    bit_q     <= 4'd0;
                                    oled_mosi <= shadow_q[15];
                                    shift_q   <= {shadow_q[14:0], 1'b0};
                                    if (pixel_index == LAST_IDX) begin
                                        last_q <= 1'b1;
                                    end else begin
                                        pixel_index <= pixel_index + 13'd1;
                                    end
`else
                                    state_q     <= StFetch;
                                    fetch_q     <= 1'b0;
                                    pixel_index <= pixel_index + 13'd1;
`endif
                                end
                            end else begin
                                bit_q     <= bit_q + 4'd1;
                                oled_mosi <= shift_q[15];
                                shift_q   <= {shift_q[14:0], 1'b0};
                            end
                        end
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Bench for oled_frame_streamer on a small 8x4 panel so whole frames fit in a short run.
module tb_oled_frame_streamer;

    localparam int unsigned W = 8;
    localparam int unsigned H = 4;
    localparam int unsigned C = 2;
    localparam int unsigned N = W * H;
`ifdef OLED_TX_PREFETCH_EN
    localparam int unsigned GAP  = 2 * C;
    localparam int unsigned SAVE = 2 * (N - 1);
`else
    localparam int unsigned GAP  = 2 * C + 2;
    localparam int unsigned SAVE = 0;
`endif
    localparam int unsigned FRAME_LEN = 6 * 8 * 2 * C + N * (2 + 32 * C) + 1 - SAVE;
    localparam int unsigned BITS      = 48 + 16 * N;

    logic        clk;
    logic        rst_n;
    logic        frame_req;
    logic [15:0] pixel_data;
    logic [12:0] pixel_index;
    logic        oled_cs_n;
    logic        oled_sclk;
    logic        oled_mosi;
    logic        oled_dc;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    oled_frame_streamer #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .CLK_DIV (C)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_req   (frame_req),
        .pixel_data  (pixel_data),
        .pixel_index (pixel_index),
        .oled_cs_n   (oled_cs_n),
        .oled_sclk   (oled_sclk),
        .oled_mosi   (oled_mosi),
        .oled_dc     (oled_dc),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel source with one clock of latency.
    logic [15:0] pix_mem [0:8191];
    always @(posedge clk) pixel_data <= pix_mem[pixel_index];

    // SPI monitor: decode bytes (dc=0) and words (dc=1) on SCLK rising edges.
    logic [15:0] acc;
    int          nbits;
    logic [16:0] rx_q [$];
    time         rise_q [$];
    always @(posedge oled_sclk or posedge oled_cs_n) begin
        if (oled_cs_n) begin
            nbits = 0;
        end else begin
            rise_q.push_back($time);
            acc = {acc[14:0], oled_mosi};
            nbits++;
            if (!oled_dc && nbits == 8) begin
                rx_q.push_back({1'b0, 8'h00, acc[7:0]});
                nbits = 0;
            end else if (oled_dc && nbits == 16) begin
                rx_q.push_back({1'b1, acc});
                nbits = 0;
            end
        end
    end

    int done_cnt = 0;
    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] cmd_exp [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < int'(N); i++) pix_mem[i] = 16'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            frame_req = 1'b0;
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pulse frame_req and count cycles from the first CMD cycle through the DONE cycle.
    task automatic run_frame(output int len, output bit ok);
        @(negedge clk);
        frame_req = 1'b1;
        len = 0;
        ok  = 1'b0;
        for (int i = 0; i < int'(FRAME_LEN) + 200; i++) begin
            @(negedge clk);
            frame_req = 1'b0;
            len++;
            if (len == 1) begin
                chk("busy_at_start", 32'(busy), 32'd1);
                chk("cs_n_at_start", 32'(oled_cs_n), 32'd0);
            end
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_stream(input int base);
        if (rx_q.size() >= base + 6 + int'(N)) begin
            for (int i = 0; i < 6; i++)
                chk("cmd_byte", 32'(rx_q[base + i]), {15'd0, 1'b0, 8'h00, cmd_exp[i]});
            for (int p = 0; p < int'(N); p++)
                chk("pixel_word", 32'(rx_q[base + 6 + p]), {15'd0, 1'b1, pix_mem[p]});
        end else begin
            chk("stream_short", 32'(rx_q.size()), 32'(base + 6 + int'(N)));
        end
    endtask

    int  len;
    bit  ok;
    int  d0;
    int  k;
    int  idx;
    int  target;

    initial begin
        cmd_exp = '{8'h15, 8'h00, 8'(W - 1), 8'h75, 8'h00, 8'(H - 1)};
        frame_req = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        fill_mem();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cs_n", 32'(oled_cs_n), 32'd1);
        chk("rst_sclk", 32'(oled_sclk), 32'd0);
        chk("rst_mosi", 32'(oled_mosi), 32'd0);
        chk("rst_dc", 32'(oled_dc), 32'd0);
        chk("rst_pixel_index", 32'(pixel_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // Single frame: command, pixel stream, length, gap between pixels.
        rx_q.delete();
        rise_q.delete();
        d0 = done_cnt;
        run_frame(len, ok);
        chk("frame1_done_seen", 32'(ok), 32'd1);
        chk("frame1_length", 32'(len), 32'(FRAME_LEN));
        @(negedge clk);
        chk("frame1_cs_n_after", 32'(oled_cs_n), 32'd1);
        chk("frame1_busy_after", 32'(busy), 32'd0);
        chk("frame1_index_after", 32'(pixel_index), 32'd0);
        chk("frame1_done_count", 32'(done_cnt - d0), 32'd1);
        chk("frame1_rx_count", 32'(rx_q.size()), 32'(6 + N));
        check_stream(0);
        chk("frame1_sclk_rises", 32'(rise_q.size()), 32'(BITS));
        if (rise_q.size() == BITS) begin
            k   = $urandom_range(0, N - 2);
            idx = 48 + 16 * k + 15;
            chk("pixel_gap", 32'((rise_q[idx + 1] - rise_q[idx]) / 10), 32'(GAP));
            chk("bit_spacing", 32'((rise_q[idx] - rise_q[idx - 1]) / 10), 32'(2 * C));
            chk("cmd_bit_spacing", 32'((rise_q[8] - rise_q[7]) / 10), 32'(2 * C));
        end

        // Request in the DONE cycle is queued and starts another frame.
        fill_mem();
        rx_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        frame_req = 1'b1;
        wait_done(FRAME_LEN + 200, ok);
        chk("doneq_first_done", 32'(ok), 32'd1);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        wait_done(FRAME_LEN + 200, ok);
        chk("doneq_second_done", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        chk("doneq_done_count", 32'(done_cnt - d0), 32'd2);
        chk("doneq_rx_count", 32'(rx_q.size()), 32'(2 * (6 + N)));
        check_stream(6 + int'(N));

        // Three extra requests during one frame collapse into one queued frame.
        fill_mem();
        rx_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            repeat ($urandom_range(50, 400)) @(negedge clk);
            frame_req = 1'b1;
            @(negedge clk);
            frame_req = 1'b0;
        end
        for (int i = 0; i < 3 * int'(FRAME_LEN) + 200; i++) begin
            @(negedge clk);
            if (done_cnt - d0 >= 2) break;
        end
        repeat (200) @(negedge clk);
        chk("queue_done_count", 32'(done_cnt - d0), 32'd2);
        chk("queue_busy_after", 32'(busy), 32'd0);
        chk("queue_rx_count", 32'(rx_q.size()), 32'(2 * (6 + N)));
        check_stream(6 + int'(N));

        // Asynchronous reset in the middle of a pixel shift, then a clean restart.
        fill_mem();
        d0 = done_cnt;
        target = $urandom_range(3, N - 3);
        @(negedge clk);
        frame_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            @(negedge clk);
            frame_req = 1'b0;
            if (pixel_index == 13'(target)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midrst_reach_pixel", 32'(ok), 32'd1);
        repeat ($urandom_range(4, 40)) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", 32'(oled_cs_n), 32'd1);
        chk("midrst_sclk", 32'(oled_sclk), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pixel_index", 32'(pixel_index), 32'd0);
        chk("midrst_dc", 32'(oled_dc), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        rx_q.delete();
        d0 = done_cnt;
        run_frame(len, ok);
        chk("restart_done_seen", 32'(ok), 32'd1);
        chk("restart_length", 32'(len), 32'(FRAME_LEN));
        @(negedge clk);
        chk("restart_done_count", 32'(done_cnt - d0), 32'd1);
        chk("restart_rx_count", 32'(rx_q.size()), 32'(6 + N));
        check_stream(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
